// File: rtl/math_pkg.sv
// Shared types and sizing helpers for the display-path arithmetic blocks.
package math_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

  // Smallest digit count d with 10**d > 2**width, i.e. enough for any width-bit magnitude.
  function automatic int unsigned bcd_digits(input int unsigned width);
    longint unsigned lim;
    longint unsigned pow;
    int unsigned     d;
    lim = 64'd1 << width;
    pow = 64'd10;
    d   = 1;
    while (pow <= lim) begin
      pow = pow * 64'd10;
      d   = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  always_comb begin
    fixed = digit;
    if (digit >= 4'd5) fixed = digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative double-dabble converter: one magnitude bit per clock behind a valid/ready handshake.
module bin_to_bcd
  import math_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_signed,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  if (DIGITS < bcd_digits(WIDTH)) begin : g_digits_check
    $error("bin_to_bcd: DIGITS too small to represent every WIDTH-bit magnitude");
  end

  bcd_state_t          state;
  bcd_state_t          state_next;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] scratch_adj;
  logic [4*DIGITS-1:0] scratch_shift;
  logic [CW-1:0]       cnt;
  logic                sign;
  logic                accept;
  logic                last;
  logic                in_neg;

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign last     = (state == SHIFT) && (cnt == CW'(1));
  assign in_neg   = in_signed && in_data[WIDTH-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (scratch[4*g +: 4]),
      .fixed (scratch_adj[4*g +: 4])
    );
  end

  assign scratch_shift = {scratch_adj[4*DIGITS-2:0], mag[WIDTH-1]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Unsigned WIDTH-bit negation maps the most negative input onto itself, which is its magnitude.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag       <= '0;
      scratch   <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      bcd       <= '0;
      negative  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        mag     <= in_neg ? -in_data : in_data;
        sign    <= in_neg;
        scratch <= '0;
        cnt     <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        scratch <= scratch_shift;
        mag     <= {mag[WIDTH-2:0], 1'b0};
        cnt     <= cnt - CW'(1);
        if (last) begin
          bcd       <= scratch_shift;
          negative  <= sign;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd against a divide/modulo decimal reference.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_signed;
  logic        out_valid;
  logic [11:0] bcd;
  logic        negative;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .bcd       (bcd),
    .negative  (negative)
  );

  // {negative, hundreds, tens, ones} from plain arithmetic on the input value
  function automatic logic [12:0] ref_model(input int v, input bit s);
    int m;
    bit n;
    n = s && (v >= 128);
    m = n ? 256 - v : v;
    return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [7:0] v, input logic s, input string tag);
    logic [12:0] e;
    int          k;
    bit          busy_ready;
    e = ref_model(int'(v), s);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_data   = v;
    in_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = 8'($urandom);
    in_signed = 1'($urandom);
    k = 0;
    busy_ready = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (in_ready && !out_valid) busy_ready = 1'b1;
    end while (!out_valid && k < 20);
    chk({tag, "_latency"}, 32'(k), 32'd9);
    chk({tag, "_bcd"}, 32'(bcd), 32'(e[11:0]));
    chk({tag, "_neg"}, 32'(negative), 32'(e[12]));
    chk({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          k;
    int          pulses;
    bit          busy_ready;
    logic [7:0]  rv;
    logic        rs;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_neg", 32'(negative), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);

    convert(8'd0,   1'b0, "u0");
    convert(8'd255, 1'b0, "u255");
    convert(8'd99,  1'b0, "u99");
    convert(8'h80,  1'b1, "s80");
    convert(8'hFF,  1'b1, "sFF");
    convert(8'h7F,  1'b1, "s7F");
    convert(8'd0,   1'b1, "s0");

    // in_valid held high across two conversions
    in_valid  = 1'b1;
    in_data   = 8'd10;
    in_signed = 1'b0;
    @(posedge clk);
    #1;
    in_data = 8'd200;
    k = 0;
    busy_ready = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (in_ready && !out_valid) busy_ready = 1'b1;
    end while (!out_valid && k < 20);
    chk("b2b_a_latency", 32'(k), 32'd9);
    chk("b2b_a_bcd", 32'(bcd), 32'h010);
    chk("b2b_a_busy_ready", 32'(busy_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("b2b_no_double_pulse", 32'(out_valid), 32'd0);
    end while (!out_valid && k < 20);
    chk("b2b_b_latency", 32'(k), 32'd9);
    chk("b2b_b_bcd", 32'(bcd), 32'h200);
    @(negedge clk);

    // reset partway through a conversion
    in_valid  = 1'b1;
    in_data   = 8'd123;
    in_signed = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_neg", 32'(negative), 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);
    convert(8'd42, 1'b0, "after_abort");

    for (int i = 0; i < 256; i++) begin
      convert(8'(i), 1'b0, "exh_u");
      convert(8'(i), 1'b1, "exh_s");
    end

    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom);
      rs = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      convert(rv, rs, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
